// File: rtl/instr_encoder_pkg.sv
// Mnemonic codes, MIPS opcode/funct constants and the packing function shared
// by the encoder and anything that needs to agree with the control decoder.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    K_ADD  = 5'd0,  K_SUB  = 5'd1,  K_AND  = 5'd2,  K_OR   = 5'd3,
    K_SLT  = 5'd4,  K_SLTU = 5'd5,  K_ADDU = 5'd6,  K_SUBU = 5'd7,
    K_NOR  = 5'd8,  K_ADDI = 5'd9,  K_ORI  = 5'd10, K_LW   = 5'd11,
    K_SW   = 5'd12, K_BEQ  = 5'd13, K_BNE  = 5'd14, K_J    = 5'd15,
    K_JAL  = 5'd16
  } kind_e;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_BAD} fmt_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic fmt_e kind_fmt(input logic [4:0] kind);
    if (kind <= K_NOR)      return FMT_R;
    else if (kind <= K_BNE) return FMT_I;
    else if (kind <= K_JAL) return FMT_J;
    else                    return FMT_BAD;
  endfunction

  // funct field for R-type kinds, primary opcode for I/J-type kinds
  function automatic logic [5:0] kind_code(input logic [4:0] kind);
    case (kind)
      K_ADD:   return FN_ADD;
      K_SUB:   return FN_SUB;
      K_AND:   return FN_AND;
      K_OR:    return FN_OR;
      K_SLT:   return FN_SLT;
      K_SLTU:  return FN_SLTU;
      K_ADDU:  return FN_ADDU;
      K_SUBU:  return FN_SUBU;
      K_NOR:   return FN_NOR;
      K_ADDI:  return OP_ADDI;
      K_ORI:   return OP_ORI;
      K_LW:    return OP_LW;
      K_SW:    return OP_SW;
      K_BEQ:   return OP_BEQ;
      K_BNE:   return OP_BNE;
      K_J:     return OP_J;
      K_JAL:   return OP_JAL;
      default: return 6'h00;
    endcase
  endfunction

  function automatic enc_t encode(input logic [4:0] kind, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [15:0] imm, input logic [25:0] target);
    enc_t       e;
    logic [5:0] code;
    code    = kind_code(kind);
    e.legal = 1'b1;
    case (kind_fmt(kind))
      FMT_R:   e.word = {OP_RTYPE, rs, rt, rd, 5'h00, code};
      FMT_I:   e.word = {code, rs, rt, imm};
      FMT_J:   e.word = {code, target};
      default: begin
        e.word  = 32'h0;
        e.legal = 1'b0;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Command handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(parameter int AW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_kind;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          im_stall;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, im_stall,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, im_stall,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Small single-clock FIFO with a combinational head; an empty FIFO presents 0.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr_reg;
  logic [PW:0]      rd_ptr_reg;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                 (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full && !clear)
      mem[wr_ptr_reg[PW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// Packs mnemonic commands into MIPS words, buffers them and streams them into
// instruction memory at consecutive word addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int BASE  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  instr_encoder_if.slave  bus,
  output logic [AW:0]     count,
  output logic [1:0]      err
);
  enc_t          enc;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic [AW-1:0] addr_reg;
  logic [AW:0]   count_reg;
  logic [1:0]    err_reg;

  assign enc = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                      bus.in_imm, bus.in_target);

  // No bypass: a full FIFO refuses input even if it is draining this cycle.
  assign bus.in_ready = ~rst & ~full & ~restart;
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = accept & enc.legal;
  assign pop          = ~empty & ~bus.im_stall & ~restart;

  assign bus.im_we    = pop;
  assign bus.im_addr  = addr_reg;
  assign bus.im_wdata = head;
  assign count        = count_reg;
  assign err          = err_reg;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (restart),
    .push  (push),
    .din   (enc.word),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= AW'(BASE);
      count_reg <= '0;
      err_reg   <= '0;
    end else if (restart) begin
      addr_reg  <= AW'(BASE);
      count_reg <= '0;
      err_reg   <= '0;
    end else begin
      if (pop) begin
        addr_reg <= addr_reg + 1'b1;
        if (&addr_reg)
          err_reg[1] <= 1'b1;
        if (!(&count_reg))
          count_reg <= count_reg + 1'b1;
      end
      if (accept && !enc.legal)
        err_reg[0] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench: an AW=8 encoder for the main scenarios and an AW=2 one for wrap.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic restart2 = 1'b0;
  logic [8:0] count;
  logic [1:0] err;
  logic [2:0] count2;
  logic [1:0] err2;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t log1[$];
  wr_t log2[$];

  instr_encoder_if #(.AW(8)) bus ();
  instr_encoder_if #(.AW(2)) bus2 ();

  instr_encoder #(.DEPTH(4), .AW(8), .BASE(0)) dut (
    .clk(clk), .rst(rst), .restart(restart), .bus(bus), .count(count), .err(err)
  );

  instr_encoder #(.DEPTH(4), .AW(2), .BASE(0)) dut2 (
    .clk(clk), .rst(rst), .restart(restart2), .bus(bus2), .count(count2), .err(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      log1.push_back('{8'(bus.im_addr), bus.im_wdata, cyc});
      $display("WR dut  addr=%0d data=%08h", bus.im_addr, bus.im_wdata);
    end
    if (bus2.im_we === 1'b1) begin
      log2.push_back('{8'(bus2.im_addr), bus2.im_wdata, cyc});
      $display("WR dut2 addr=%0d data=%08h", bus2.im_addr, bus2.im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bus.in_kind = k; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_imm = imm; bus.in_target = tgt; bus.in_valid = 1'b1;
  endtask

  task automatic push(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    set_cmd(k, rs, rt, rd, imm, tgt);
    #1;
    chk("push_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push2(input logic [4:0] rt, input logic [15:0] imm);
    bus2.in_kind = 5'd10; bus2.in_rs = 5'd0; bus2.in_rt = rt; bus2.in_rd = 5'd0;
    bus2.in_imm = imm; bus2.in_target = '0; bus2.in_valid = 1'b1;
    #1;
    chk("push2_ready", 32'(bus2.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    bus.in_valid = 0; bus.in_kind = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0;
    bus.in_imm = 0; bus.in_target = 0; bus.im_stall = 0;
    bus2.in_valid = 0; bus2.in_kind = 0; bus2.in_rs = 0; bus2.in_rt = 0; bus2.in_rd = 0;
    bus2.in_imm = 0; bus2.in_target = 0; bus2.im_stall = 0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_im_we", 32'(bus.im_we), 32'd0);
    chk("rst_im_addr", 32'(bus.im_addr), 32'd0);
    chk("rst_im_wdata", bus.im_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Single add, latency and count
    push(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    #1;
    chk("add_we", 32'(bus.im_we), 32'd1);
    chk("add_addr", 32'(bus.im_addr), 32'd0);
    chk("add_wdata", bus.im_wdata, 32'h00221820);
    chk("add_count_before", 32'(count), 32'd0);
    tick();
    chk("add_count_after", 32'(count), 32'd1);
    chk("add_we_drained", 32'(bus.im_we), 32'd0);

    // Restart, then four back-to-back commands
    restart = 1'b1;
    tick();
    restart = 1'b0;
    #1;
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_addr", 32'(bus.im_addr), 32'd0);
    log1.delete();
    push(5'd9,  5'd0,  5'd8, 5'd0, 16'h0005, 26'h0);
    push(5'd11, 5'd29, 5'd9, 5'd0, 16'hFFFC, 26'h0);
    push(5'd16, 5'd0,  5'd0, 5'd0, 16'h0,    26'h100);
    push(5'd8,  5'd4,  5'd5, 5'd6, 16'h0,    26'h0);
    tick(); tick();
    chk("b2b_nwrites", 32'(log1.size()), 32'd4);
    if (log1.size() == 4) begin
      chk("b2b_a0", 32'(log1[0].addr), 32'd0); chk("b2b_d0", log1[0].data, 32'h20080005);
      chk("b2b_a1", 32'(log1[1].addr), 32'd1); chk("b2b_d1", log1[1].data, 32'h8FA9FFFC);
      chk("b2b_a2", 32'(log1[2].addr), 32'd2); chk("b2b_d2", log1[2].data, 32'h0C000100);
      chk("b2b_a3", 32'(log1[3].addr), 32'd3); chk("b2b_d3", log1[3].data, 32'h00853027);
      chk("b2b_throughput", 32'(log1[3].cyc - log1[0].cyc), 32'd3);
    end
    chk("b2b_count", 32'(count), 32'd4);

    // Stall until full, then release
    bus.im_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(5'd9, 5'd0, 5'(i), 5'd0, 16'(16 + i), 26'h0);
      #1;
      chk("stall_ready", 32'(bus.in_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    chk("stall_no_we", 32'(bus.im_we), 32'd0);
    chk("stall_addr", 32'(bus.im_addr), 32'd4);
    chk("stall_wdata", bus.im_wdata, 32'h20000010);
    chk("stall_no_writes", 32'(log1.size()), 32'd4);
    bus.im_stall = 1'b0;
    #1;
    chk("unstall_we", 32'(bus.im_we), 32'd1);
    n = 0;
    while (!bus.in_ready && n < 10) begin
      tick();
      n++;
    end
    chk("unstall_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    chk("stall_nwrites", 32'(log1.size()), 32'd9);
    if (log1.size() == 9) begin
      for (int i = 0; i < 5; i++) begin
        chk("stall_wr_addr", 32'(log1[4+i].addr), 32'(4 + i));
        chk("stall_wr_data", log1[4+i].data, 32'h20000000 | 32'(i << 16) | 32'(16 + i));
      end
      for (int k = 0; k < 3; k++)
        chk("stall_consecutive", 32'(log1[5+k].cyc - log1[4+k].cyc), 32'd1);
    end

    // Illegal kind, then beq
    push(5'd20, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick(); tick();
    chk("illegal_nowrite", 32'(log1.size()), 32'd9);
    chk("illegal_err", 32'(err), 32'd1);
    push(5'd13, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    tick(); tick();
    chk("beq_nwrites", 32'(log1.size()), 32'd10);
    if (log1.size() == 10) begin
      chk("beq_addr", 32'(log1[9].addr), 32'd9);
      chk("beq_data", log1[9].data, 32'h1022FFFF);
    end
    chk("beq_err", 32'(err), 32'd1);

    // Reset mid-stream with three words buffered
    bus.im_stall = 1'b1;
    push(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    push(5'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    push(5'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    bus.im_stall = 1'b0;
    #1;
    chk("midrst_we_before", 32'(bus.im_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_we", 32'(bus.im_we), 32'd0);
    chk("midrst_wdata", bus.im_wdata, 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    tick(); tick();
    rst = 1'b0;
    log1.delete();
    #1;
    chk("postrst_addr", 32'(bus.im_addr), 32'd0);
    chk("postrst_err", 32'(err), 32'd0);
    chk("postrst_empty_we", 32'(bus.im_we), 32'd0);
    push(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick(); tick();
    chk("postrst_nwrites", 32'(log1.size()), 32'd1);
    if (log1.size() == 1) begin
      chk("postrst_wr_addr", 32'(log1[0].addr), 32'd0);
      chk("postrst_wr_data", log1[0].data, 32'h00221820);
    end
    chk("postrst_count", 32'(count), 32'd1);

    // AW=2 address wrap
    log2.delete();
    for (int i = 0; i < 5; i++) push2(5'(i), 16'(i));
    tick(); tick(); tick();
    chk("wrap_nwrites", 32'(log2.size()), 32'd5);
    if (log2.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("wrap_addr", 32'(log2[i].addr), 32'(i % 4));
        chk("wrap_data", log2[i].data, 32'h34000000 | 32'(i << 16) | 32'(i));
      end
    end
    chk("wrap_err", 32'(err2), 32'd2);
    chk("wrap_count", 32'(count2), 32'd5);
    restart2 = 1'b1;
    #1;
    chk("restart2_ready", 32'(bus2.in_ready), 32'd0);
    tick();
    restart2 = 1'b0;
    #1;
    chk("restart2_err", 32'(err2), 32'd0);
    chk("restart2_count", 32'(count2), 32'd0);
    chk("restart2_addr", 32'(bus2.im_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and loader: the write-side counterpart of the control decoder. It accepts mnemonic-plus-field commands over a valid/ready handshake and packs each command into a 32-bit MIPS word using the same opcode and funct encodings the decoder recognises. Words are buffered in a small FIFO and streamed into the instruction memory write port at consecutive word addresses. Used by the simulation harness and the boot loader to build test programs in place.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 8, instruction-memory word-address width
- BASE, 0, first word address after reset/restart

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- restart  in  1  sync: flush FIFO, address←BASE, clear err/count
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid&in_ready at rising edge
- in_kind  in  5  mnemonic code (see Operation)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- im_stall  in  1  memory busy; hold current write
- im_we  out  1  write strobe
- im_addr  out  AW  word address
- im_wdata  out  32  encoded instruction
- count  out  AW+1  words written since reset/restart, saturating
- err  out  2  sticky: [0] illegal in_kind, [1] address wrapped

## Operation
- Mnemonic codes 0–16: add, sub, and, or, slt, sltu, addu, subu, nor, addi, ori, lw, sw, beq, bne, j, jal. Codes 17–31 are illegal.
- R-type word is {6'h00, rs, rt, rd, 5'h0, funct}. funct: add 20, sub 22, and 24, or 25, slt 2A, sltu 2B, addu 21, subu 23, nor 27 (hex).
- I-type word is {op, rs, rt, imm}. op: addi 08, ori 0D, lw 23, sw 2B, beq 04, bne 05.
- J-type word is {op, target}. op: j 02, jal 03.
- Fields not used by the format are ignored.
- Encoding is combinational on the inputs. On acceptance the encoded word is pushed to the FIFO.
- An illegal code is consumed (handshake completes), nothing is pushed, and err[0] is set.
- in_ready = ~rst & ~full & ~restart. There is no bypass: a full FIFO refuses input even when a pop occurs in the same cycle.
- Drain: im_we = ~empty & ~im_stall. im_wdata is the FIFO head and im_addr is the address register.
- On each edge with im_we=1: pop, address+1, count+1 (count saturates at all-ones).
- Address wraps from 2^AW−1 to 0; err[1] is set on that wrap.
- restart has priority over push and pop in the same cycle. Nothing is written in that cycle (im_we forced 0).

## Timing
- Reset values:
  - in_ready 0 while rst is high, 1 in the first cycle after release
  - im_we 0, im_addr BASE, im_wdata 0 (empty FIFO reads as 0)
  - count 0, err 0, FIFO empty
- Latency: a command accepted at edge N is visible on im_* in cycle N+1 when the FIFO was empty, and is written at edge N+1 when im_stall=0.
- Throughput: one word per cycle sustained when im_stall=0.
- im_stall=1 holds im_addr and im_wdata stable with im_we=0. Input can still be accepted until the FIFO is full.
- Simultaneous push and pop on a non-full FIFO leaves the occupancy unchanged.
- rst asserted mid-stream drops all buffered words immediately, asynchronously.

## Structure
- Shared package/include `instr_encode_def`:
  - mnemonic codes
  - opcode and funct constants, the same values used by the decoder's include
  - format selector encoding (R/I/J)
- Sub-module `sync_fifo` (parameters DEPTH, width 32; ports push, pop, full, empty, head).
- Encoder logic, address and count registers, and err flags live in the top level.

## Test plan
- Reset, then push add (rs=1, rt=2, rd=3) → im_we=1 the next cycle, im_addr=0, im_wdata=0x00221820; count=1 after the edge.
- Push addi (rs=0, rt=8, imm=0x0005), lw (rs=29, rt=9, imm=0xFFFC), jal (target=0x100), nor (rs=4, rt=5, rd=6) back-to-back → addresses 0–3 receive 0x20080005, 0x8FA9FFFC, 0x0C000100, 0x00853027.
- Hold im_stall=1 and push 5 commands with DEPTH=4 → in_ready falls after the 4th; no write occurs. Release im_stall → 4 writes on consecutive cycles, then the 5th is accepted.
- Push in_kind=20 → handshake completes, no write, err=2'b01. Then a valid beq (rs=1, rt=2, imm=0xFFFF) → 0x1022FFFF is written at the next address.
- AW=2: write 5 words → the 5th goes to address 0, err[1]=1, count=5. Then assert restart → err=0, count=0, address BASE.
- Assert rst mid-stream with 3 words buffered → im_we=0 at once, FIFO empty; after release, a new push is written at BASE.
